// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says datapath blocks.
package simon_pkg;

  localparam int LEVEL_W   = 4;
  localparam int MEM_DEPTH = 16;
  localparam int BTN_W     = 4;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } color_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    COMPARE,
    WAIT_RELEASE,
    PASS,
    FAIL
  } checker_state_t;

  function automatic logic is_one_hot(input logic [BTN_W-1:0] v);
    return (v != '0) && ((v & (v - BTN_W'(1))) == '0);
  endfunction

  // Only meaningful for one-hot inputs; the caller rejects anything else.
  function automatic color_t encode_color(input logic [BTN_W-1:0] v);
    color_t c;
    c = RED;
    if (v[3])      c = YELLOW;
    else if (v[2]) c = BLUE;
    else if (v[1]) c = GREEN;
    return c;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raises stable while the button vector has held one value for at least
// DEBOUNCE_CYCLES consecutive cycles, counting the current cycle.
module button_debouncer
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BTN_W-1:0] buttons,
  output logic             stable
);

  logic [BTN_W-1:0] prev;
  logic [7:0]       count;
  logic [7:0]       run;

  // Length of the current run including this cycle, saturating at 255.
  always_comb begin
    run = 8'd1;
    if (buttons == prev)
      run = (count == 8'hFF) ? count : count + 8'd1;
  end

  assign stable = (run >= 8'(DEBOUNCE_CYCLES));

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev  <= '0;
      count <= '0;
    end else begin
      prev  <= buttons;
      count <= run;
    end
  end

endmodule

// File: rtl/input_checker.sv
// Simon Says player-response checker: compares debounced presses against the
// stored sequence. Define INPUT_CHECKER_TIMEOUT_EN to build the press timeout.
module input_checker
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEVEL_W-1:0] level,
  input  logic [BTN_W-1:0]   buttons,
  input  logic [1:0]         expected,
  output logic [LEVEL_W-1:0] address,
  output logic               busy,
  output logic               pass,
  output logic               fail,
  output logic [BTN_W-1:0]   led_echo
);

  checker_state_t     state, next_state;
  logic [LEVEL_W-1:0] idx;
  logic [LEVEL_W-1:0] level_q;
  logic [BTN_W-1:0]   latched;
  logic               stable;
  logic               timeout;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
    .clk     (clk),
    .reset   (reset),
    .buttons (buttons),
    .stable  (stable)
  );

`ifdef INPUT_CHECKER_TIMEOUT_EN
  logic [23:0] wait_count;

  // Held at zero outside WAIT_PRESS, so every entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (!reset || state != WAIT_PRESS) wait_count <= '0;
    else                               wait_count <= wait_count + 24'd1;
  end

  assign timeout = (state == WAIT_PRESS) && (wait_count == 24'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      level_q  <= '0;
      latched  <= '0;
      led_echo <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE:
          if (start && level != '0) begin
            level_q <= level;
            idx     <= '0;
          end
        WAIT_PRESS:
          if (stable && buttons != '0) latched <= buttons;
        COMPARE:
          if (next_state == WAIT_RELEASE) begin
            idx      <= idx + LEVEL_W'(1);
            led_echo <= latched;
          end
        WAIT_RELEASE:
          if (next_state != WAIT_RELEASE) led_echo <= '0;
        default: ;
      endcase
    end
  end

  // A press accepted in the same cycle the timeout expires wins.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:
        if (start) next_state = (level == '0) ? PASS : WAIT_PRESS;
      WAIT_PRESS:
        if (stable && buttons != '0) next_state = COMPARE;
        else if (timeout)            next_state = FAIL;
      COMPARE:
        if (!is_one_hot(latched) || encode_color(latched) != color_t'(expected))
          next_state = FAIL;
        else
          next_state = WAIT_RELEASE;
      WAIT_RELEASE:
        if (stable && buttons == '0)
          next_state = (idx == level_q) ? PASS : WAIT_PRESS;
      PASS:    next_state = IDLE;
      FAIL:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign address = idx;
  assign busy    = (state != IDLE);
  assign pass    = (state == PASS);
  assign fail    = (state == FAIL);

endmodule

// File: tb/tb_input_checker.sv
// Directed bench for input_checker with a small synchronous sequence memory.
// The timeout scenario changes shape when INPUT_CHECKER_TIMEOUT_EN is defined.
module tb_input_checker;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] level;
  logic [3:0] buttons;
  logic [1:0] expected;
  logic [3:0] address;
  logic       busy;
  logic       pass;
  logic       fail;
  logic [3:0] led_echo;

  logic [1:0] mem [16];
  logic [3:0] seq_led [6];
  int compared;
  int mismatched;

  input_checker #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(1000)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .level    (level),
    .buttons  (buttons),
    .expected (expected),
    .address  (address),
    .busy     (busy),
    .pass     (pass),
    .fail     (fail),
    .led_echo (led_echo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sequence memory with one cycle of read latency.
  always_ff @(posedge clk) expected <= mem[address];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] btns, input int cycles);
    buttons = btns;
    repeat (cycles) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] required);
    compared++;
    assert (observed === required) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, required);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    mem[0] = 2'd0; mem[1] = 2'd1; mem[2] = 2'd2;
    mem[3] = 2'd3; mem[4] = 2'd0; mem[5] = 2'd1;
    seq_led[0] = 4'b0001; seq_led[1] = 4'b0010; seq_led[2] = 4'b0100;
    seq_led[3] = 4'b1000; seq_led[4] = 4'b0001; seq_led[5] = 4'b0010;

    reset = 1'b0; start = 1'b0; level = 4'd0; buttons = 4'd0;
    repeat (2) tick();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_pass", pass, 0);
    checkOutput("reset_fail", fail, 0);
    checkOutput("reset_address", address, 0);
    checkOutput("reset_led", led_echo, 0);
    reset = 1'b1;
    tick();

    // Full correct sequence of six presses.
    $display("[TB] scenario: correct sequence, level 6");
    start = 1'b1; level = 4'd6;
    tick();
    start = 1'b0; level = 4'd0;
    checkOutput("t1_busy_after_start", busy, 1);
    checkOutput("t1_address_start", address, 0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(seq_led[k], 4);
      tick();
      checkOutput("t1_led_echo", led_echo, seq_led[k]);
      checkOutput("t1_address_step", address, k + 1);
      applyStimulus(4'b0000, 4);
      if (k < 5) begin
        checkOutput("t1_no_early_pass", pass, 0);
        checkOutput("t1_led_cleared", led_echo, 0);
      end
    end
    checkOutput("t1_pass", pass, 1);
    checkOutput("t1_no_fail", fail, 0);
    checkOutput("t1_address_end", address, 6);
    tick();
    checkOutput("t1_pass_one_cycle", pass, 0);
    checkOutput("t1_busy_dropped", busy, 0);

    // Third press is the wrong color.
    $display("[TB] scenario: wrong third color");
    start = 1'b1; level = 4'd6;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(seq_led[k], 4);
      tick();
      applyStimulus(4'b0000, 4);
    end
    applyStimulus(4'b1000, 4);
    checkOutput("t2_compare_no_fail", fail, 0);
    checkOutput("t2_compare_busy", busy, 1);
    tick();
    checkOutput("t2_fail", fail, 1);
    checkOutput("t2_no_pass", pass, 0);
    checkOutput("t2_no_led", led_echo, 0);
    tick();
    checkOutput("t2_fail_one_cycle", fail, 0);
    checkOutput("t2_idle", busy, 0);
    applyStimulus(4'b0000, 2);

    // Two buttons pressed together.
    $display("[TB] scenario: multi-press");
    start = 1'b1; level = 4'd6;
    tick();
    start = 1'b0;
    applyStimulus(4'b0101, 4);
    tick();
    checkOutput("t3_fail", fail, 1);
    checkOutput("t3_address", address, 0);
    tick();
    checkOutput("t3_idle", busy, 0);
    applyStimulus(4'b0000, 2);

    // Short glitch followed by silence.
    $display("[TB] scenario: glitch then silence");
    start = 1'b1; level = 4'd3;
    tick();
    start = 1'b0;
    applyStimulus(4'b0010, 2);
    applyStimulus(4'b0000, 997);
    checkOutput("t4_no_fail_yet", fail, 0);
    checkOutput("t4_still_busy", busy, 1);
    checkOutput("t4_glitch_rejected", led_echo, 0);
    tick();
`ifdef INPUT_CHECKER_TIMEOUT_EN
    checkOutput("t4_timeout_fail", fail, 1);
    checkOutput("t4_timeout_no_pass", pass, 0);
    tick();
    checkOutput("t4_idle", busy, 0);
`else
    checkOutput("t4_no_timeout", fail, 0);
    checkOutput("t4_waits", busy, 1);
    checkOutput("t4_address", address, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checkOutput("t4_idle_after_reset", busy, 0);
`endif

    // Level 0 passes at once; a start during PASS is ignored.
    $display("[TB] scenario: level 0");
    start = 1'b1; level = 4'd0;
    tick();
    checkOutput("t5_pass", pass, 1);
    checkOutput("t5_busy", busy, 1);
    checkOutput("t5_no_fail", fail, 0);
    tick();
    start = 1'b0;
    checkOutput("t5_pass_one_cycle", pass, 0);
    checkOutput("t5_start_ignored", busy, 0);
    tick();
    checkOutput("t5_no_second_pass", pass, 0);

    // Reset in the middle of a release.
    $display("[TB] scenario: reset mid-release");
    start = 1'b1; level = 4'd6;
    tick();
    start = 1'b0;
    applyStimulus(4'b0001, 4);
    tick();
    checkOutput("t6_led_before_reset", led_echo, 4'b0001);
    checkOutput("t6_address_before_reset", address, 1);
    applyStimulus(4'b0000, 2);
    reset = 1'b0;
    tick();
    checkOutput("t6_reset_busy", busy, 0);
    checkOutput("t6_reset_pass", pass, 0);
    checkOutput("t6_reset_fail", fail, 0);
    checkOutput("t6_reset_address", address, 0);
    checkOutput("t6_reset_led", led_echo, 0);
    reset = 1'b1;
    tick();
    checkOutput("t6_no_pulse_pass", pass, 0);
    checkOutput("t6_no_pulse_fail", fail, 0);
    start = 1'b1; level = 4'd1;
    tick();
    start = 1'b0;
    checkOutput("t6_fresh_address", address, 0);
    checkOutput("t6_fresh_busy", busy, 1);
    applyStimulus(4'b0001, 4);
    tick();
    checkOutput("t6_fresh_led", led_echo, 4'b0001);
    checkOutput("t6_fresh_address_step", address, 1);
    applyStimulus(4'b0000, 4);
    checkOutput("t6_fresh_pass", pass, 1);
    tick();
    checkOutput("t6_fresh_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/input_checker.md
# input_checker

Player-response stage of the Simon Says game: sits directly downstream of the LED blinker. Once the game FSM sees the blinker finish a playback, it pulses `start`. This block then reads the stored color sequence from the 16x2 sequence memory, one entry per accepted press, and compares it against debounced player button presses. It reports a single `pass` or `fail` pulse back to the FSM.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles needed to accept a press or a release (legal range 1..255).
- `TIMEOUT_CYCLES`, default 1000: idle cycles allowed in WAIT_PRESS before a fail (legal range 1..2^24-1).

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request from the FSM to begin checking.
- `level`  in  4  number of sequence entries to check; sampled only on an accepted `start`.
- `buttons`  in  4  raw player buttons, active-high; `buttons[k]` means color k.
- `expected`  in  2  memory read data (`out_num`); valid one cycle after `address` changes.
- `address`  out  4  memory read address; the memory's `rw` is driven 0 by the top level during checking.
- `busy`  out  1  high in every state except IDLE.
- `pass`  out  1  one-cycle pulse: the whole sequence was matched.
- `fail`  out  1  one-cycle pulse for any of: wrong color, several buttons pressed at once, or timeout.
- `led_echo`  out  4  one-hot copy of the accepted button; held during WAIT_RELEASE, 0 otherwise.

## Operation
States: IDLE, WAIT_PRESS, COMPARE, WAIT_RELEASE, PASS, FAIL.

- **IDLE**
  - `start`=1 and `level`=0: go to PASS.
  - `start`=1 and `level`≠0: latch `level`, set idx=0 and `address`=0, go to WAIT_PRESS.
- **WAIT_PRESS**
  - The timeout counter is cleared on every entry.
  - A nonzero `buttons` value held identical for `DEBOUNCE_CYCLES` cycles is accepted: latch it, go to COMPARE.
  - A value that changes restarts the stability count.
- **COMPARE**
  - Latched value not one-hot: go to FAIL.
  - Its encoded color ≠ `expected`: go to FAIL.
  - Otherwise: idx++, `address`=idx, set `led_echo`, go to WAIT_RELEASE.
- **WAIT_RELEASE**
  - Requires `buttons`==0 for `DEBOUNCE_CYCLES` consecutive cycles.
  - Then: idx==latched level goes to PASS; otherwise back to WAIT_PRESS.
  - No timeout applies in this state.
- **PASS / FAIL**: assert the matching pulse for exactly one cycle, then return to IDLE.

Boundary conditions:
- `start` while `busy` is ignored.
- `level`=15 is legal; idx counts to 15, and `address` never exceeds 14 while a compare is pending.
- Reset mid-check returns to IDLE immediately with no pulse.
- `pass` and `fail` are never high together.

## Timing
- Every output resets to 0, and IDLE is entered in the same edge that samples `reset`=0.
- `start` sampled at edge N gives `busy`=1 from cycle N+1.
- A press stable from cycle P is accepted at the end of cycle P+`DEBOUNCE_CYCLES`-1. COMPARE is the following cycle.
- `address` changes in COMPARE. WAIT_RELEASE lasts at least 1 cycle, so `expected` is valid on the next COMPARE.
- The timeout fires when the counter reaches `TIMEOUT_CYCLES`. FAIL is the next cycle.
- `level`=0: `pass` is seen 1 cycle after `start`.

## Configuration
- `INPUT_CHECKER_TIMEOUT_EN` defined: the timeout counter is built and a timeout causes FAIL.
- Undefined: the counter is removed. WAIT_PRESS waits indefinitely, and `TIMEOUT_CYCLES` is accepted but unused.

## Structure
- Package `simon_pkg` holds:
  - `color_t` (2-bit enum RED, GREEN, BLUE, YELLOW = 0..3);
  - `checker_state_t`;
  - `LEVEL_W`=4 and `MEM_DEPTH`=16.
- Sub-module `button_debouncer` is parameterized by `DEBOUNCE_CYCLES`. It takes the 4-bit vector and outputs a stable-value strobe. It is used for both press and release detection.

## Test plan
- Memory holds 0,1,2,3,0,1; `level`=6; correct presses with 4-cycle holds and releases → single `pass`, `busy` drops the cycle after it, `address` steps 0..6.
- Same memory; third press is color 3 instead of 2 → `fail` in the cycle after COMPARE, no `pass`, back in IDLE.
- Buttons 4'b0101 held 4 cycles → `fail` (multi-press).
- 2-cycle glitch on `buttons[1]` then silence, with the macro defined and `TIMEOUT_CYCLES`=1000 → glitch is not accepted, and `fail` comes 1000 cycles after WAIT_PRESS entry.
- `level`=0 with `start` → `pass` exactly 1 cycle later; second `start` while `busy` is ignored.
- `reset`=0 asserted mid-release → all outputs 0 on the next cycle, no pulse, and a fresh `start` checks from `address` 0.
